fifo_burst_reader: RTL and testbench

Read-side controller for the RSA data FIFO. On a start command it drains exactly `len` words from the FIFO: it drives `fifo_rd_en`, absorbs the FIFO's one-cycle read latency, and re-presents the words on a valid/ready stream toward the RSA datapath. A 2-entry output buffer sustains one word per cycle under continuous `m_ready`. The block pairs with the FIFO write side and terminates the FIFO read port.

---
 rtl/fifo_burst_reader_pkg.sv | 17 +
 rtl/fifo_burst_reader_if.sv | 43 ++++
 rtl/fifo_burst_reader_skid_buf.sv | 69 ++++++
 rtl/fifo_burst_reader.sv | 118 +++++++++++
 tb/tb_fifo_burst_reader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// rtl/fifo_burst_reader_pkg.sv - shared types and constants for the RSA FIFO read side
// Contents: read-controller state enum, output buffer depth, default widths
// shared with the FIFO write side.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int RD_BUF_DEPTH = 2;

    localparam int DEF_RSA_DW = 8;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port plus output word stream
// Signals: fifo_empty/fifo_rd_en/fifo_data (FIFO read port),
// m_valid/m_data/m_ready (output stream), m_last when FIFO_RD_LAST_EN is defined.
// Modports: master = burst reader side, slave = FIFO plus downstream consumer.
interface fifo_burst_reader_if #(
    parameter int RSA_DW = fifo_burst_reader_pkg::DEF_RSA_DW
);

    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [RSA_DW-1:0] fifo_data;
    logic              m_valid;
    logic [RSA_DW-1:0] m_data;
    logic              m_ready;
`ifdef FIFO_RD_LAST_EN
    logic              m_last;
`endif

    modport master (
        input  fifo_empty,
        output fifo_rd_en,
        input  fifo_data,
        output m_valid,
        output m_data,
`ifdef FIFO_RD_LAST_EN
        output m_last,
`endif
        input  m_ready
    );

    modport slave (
        output fifo_empty,
        input  fifo_rd_en,
        output fifo_data,
        input  m_valid,
        input  m_data,
`ifdef FIFO_RD_LAST_EN
        input  m_last,
`endif
        output m_ready
    );

endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// rtl/fifo_burst_reader_skid_buf.sv - 2-entry push/pop word buffer (rsa_skid_buf)
// Ports: clk, sys_rst_n (async, active-low), push/push_data[/push_last],
// pop, head_data[/head_last], head_valid, occ (0..2).
// Optional last bit per entry when FIFO_RD_LAST_EN is defined.
module rsa_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DW = DEF_RSA_DW
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
`ifdef FIFO_RD_LAST_EN
    input  logic          push_last,
    output logic          head_last,
`endif
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_valid,
    output logic [1:0]    occ
);

    logic [DW-1:0] data_q [RD_BUF_DEPTH];
`ifdef FIFO_RD_LAST_EN
    logic          last_q [RD_BUF_DEPTH];
`endif
    logic          wr_ptr;
    logic          rd_ptr;

    // The caller's credit rule keeps push into a full buffer impossible,
    // so occ never needs saturation here.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                data_q[i] <= '0;
`ifdef FIFO_RD_LAST_EN
                last_q[i] <= 1'b0;
`endif
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
`ifdef FIFO_RD_LAST_EN
                last_q[wr_ptr] <= push_last;
`endif
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_valid = (occ != 2'd0);
    assign head_data  = data_q[rd_ptr];
`ifdef FIFO_RD_LAST_EN
    assign head_last  = head_valid && last_q[rd_ptr];
`endif

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read controller for the RSA data FIFO
// Ports: clk, sys_rst_n (async, active-low), start/len (burst command),
// busy/done (status), bus (fifo_burst_reader_if.master: FIFO read port + output stream).
// Optional macro FIFO_RD_LAST_EN adds m_last on the final word of each burst.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int RSA_DW = DEF_RSA_DW,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    fifo_burst_reader_if.master bus
);

    rd_state_t         state;
    logic [LEN_W-1:0]  rem;
    logic              inflight;
    logic [1:0]        occ;
    logic              pop;
    logic              credit_ok;
    logic              rd_en;
    logic              drain_done;
    logic [RSA_DW-1:0] head_data;
    logic              head_valid;
`ifdef FIFO_RD_LAST_EN
    logic              inflight_last;
    logic              head_last;
`endif

    assign pop = head_valid && bus.m_ready;

    // Words buffered plus the one in flight, after this cycle's pop, must
    // leave room for the read issued now; its data lands two edges later.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'(RD_BUF_DEPTH) + {2'b00, pop});

    assign rd_en = (state == READ) && !bus.fifo_empty && (rem != '0) && credit_ok;

    // Look-ahead so done lands in the cycle right after the last pop.
    assign drain_done = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    rsa_skid_buf #(
        .DW (RSA_DW)
    ) u_skid_buf (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .push       (inflight),
        .push_data  (bus.fifo_data),
`ifdef FIFO_RD_LAST_EN
        .push_last  (inflight_last),
        .head_last  (head_last),
`endif
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .occ        (occ)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef FIFO_RD_LAST_EN
            inflight_last <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= rd_en;
`ifdef FIFO_RD_LAST_EN
            inflight_last <= rd_en && (rem == LEN_W'(1));
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem <= len;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_en) begin
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = head_valid;
    assign bus.m_data     = head_data;
`ifdef FIFO_RD_LAST_EN
    assign bus.m_last     = head_last;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    fifo_burst_reader_if #(.RSA_DW(8)) bus();

    fifo_burst_reader #(.RSA_DW(8), .LEN_W(8)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, one-cycle read latency.
    logic       tb_fifo_empty = 1'b1;
    logic [7:0] tb_fifo_data = 8'd0;
    logic [7:0] fifo_q[$];
    logic [7:0] stage_mem [4096];
    int         stage_wr = 0;
    int         stage_rd = 0;
    logic [7:0] model_q[$];

    assign bus.fifo_empty = tb_fifo_empty;
    assign bus.fifo_data  = tb_fifo_data;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fifo_q.size() != 0) begin
            tb_fifo_data <= fifo_q.pop_front();
        end
        while (stage_rd < stage_wr) begin
            fifo_q.push_back(stage_mem[stage_rd]);
            stage_rd++;
        end
        tb_fifo_empty <= (fifo_q.size() == 0);
    end

    // Observation of the DUT, sampled on the falling edge.
    int         cyc = 0;
    int         rd_count = 0;
    int         done_count = 0;
    int         viol_empty = 0;
    int         viol_hold = 0;
    int         viol_buf = 0;
    int         out_cnt = 0;
    int         last_acc_cyc = 0;
    int         done_cyc = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] acc_q[$];
    bit         acc_last_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!sys_rst_n) begin
            prev_stall = 1'b0;
            out_cnt    = 0;
        end else begin
            if (bus.fifo_rd_en) begin
                rd_count++;
                out_cnt++;
                if (bus.fifo_empty) viol_empty++;
            end
            if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data)) viol_hold++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (bus.m_valid && bus.m_ready) begin
                acc_q.push_back(bus.m_data);
`ifdef FIFO_RD_LAST_EN
                acc_last_q.push_back(bus.m_last);
`else
                acc_last_q.push_back(1'b0);
`endif
                last_acc_cyc = cyc;
                out_cnt--;
            end
            if (out_cnt > 2) viol_buf++;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        stage_mem[stage_wr] = w;
        stage_wr++;
        model_q.push_back(w);
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done_count > base) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (done_count > base) ok = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %h expected 00", bus.m_data); end
`ifdef FIFO_RD_LAST_EN
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
`endif
        step(1);
        sys_rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        int rd_seen = 0;
        logic [7:0] exp_w;
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        step(3);
        bus.m_ready = 1'b1;
        start = 1'b1;
        len   = 8'd4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd_seen++;
            checks++;
            if (bus.m_valid !== (k >= 3 && k <= 6)) begin
                failures++; $display("FAIL basic_valid c%0d: got %b", k, bus.m_valid);
            end
            if (k >= 3 && k <= 6) begin
                exp_w = 8'h11 + 8'(k - 3);
                checks++;
                if (bus.m_data !== exp_w) begin failures++; $display("FAIL basic_data c%0d: got %h expected %h", k, bus.m_data, exp_w); end
            end
            checks++;
            if (done !== (k == 7)) begin failures++; $display("FAIL basic_done c%0d: got %b", k, done); end
            checks++;
            if (busy !== (k >= 1 && k <= 6)) begin failures++; $display("FAIL basic_busy c%0d: got %b", k, busy); end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++;
        if (rd_seen != 4) begin failures++; $display("FAIL basic_rd_count: got %0d expected 4", rd_seen); end
        repeat (4) void'(model_q.pop_front());
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len   = 8'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (done !== (k == 1)) begin failures++; $display("FAIL len0_done c%0d: got %b", k, done); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy c%0d: got %b expected 0", k, busy); end
            checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL len0_rd_en c%0d: got %b expected 0", k, bus.fifo_rd_en); end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int base_rd, base_acc, base_done, base_vh;
        bit ok;
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        step(3);
        bus.m_ready = 1'b0;
        base_rd = rd_count; base_acc = acc_q.size(); base_done = done_count; base_vh = viol_hold;
        start = 1'b1;
        len   = 8'd5;
        step(1);
        start = 1'b0;
        step(7);
        @(negedge clk);
        checks++; if (rd_count - base_rd != 2) begin failures++; $display("FAIL bp_reads: got %0d expected 2", rd_count - base_rd); end
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", bus.m_valid); end
        checks++; if (bus.m_data !== model_q[0]) begin failures++; $display("FAIL bp_head: got %h expected %h", bus.m_data, model_q[0]); end
        step(1);
        bus.m_ready = 1'b1;
        wait_done(base_done, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout: got no done expected done"); end
        checks++; if (acc_q.size() - base_acc != 5) begin failures++; $display("FAIL bp_count: got %0d expected 5", acc_q.size() - base_acc); end
        for (int i = 0; i < 5 && base_acc + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[base_acc + i] !== model_q[i]) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", i, acc_q[base_acc + i], model_q[i]); end
        end
        checks++; if (viol_hold != base_vh) begin failures++; $display("FAIL bp_hold: got %0d changes expected 0", viol_hold - base_vh); end
        repeat (5) void'(model_q.pop_front());
        step(2);
    endtask

    task automatic test_empty_stall();
        int base_rd, base_acc, base_done, base_ve;
        bit ok;
        push_word(8'($urandom));
        push_word(8'($urandom));
        step(3);
        bus.m_ready = 1'b1;
        base_rd = rd_count; base_acc = acc_q.size(); base_done = done_count; base_ve = viol_empty;
        start = 1'b1;
        len   = 8'd4;
        step(1);
        start = 1'b0;
        step(12);
        @(negedge clk);
        checks++; if (acc_q.size() - base_acc != 2) begin failures++; $display("FAIL stall_partial: got %0d expected 2", acc_q.size() - base_acc); end
        checks++; if (rd_count - base_rd != 2) begin failures++; $display("FAIL stall_reads: got %0d expected 2", rd_count - base_rd); end
        checks++; if (busy !== 1'b1 || done_count != base_done) begin failures++; $display("FAIL stall_status: got busy %b dones %0d expected 1 0", busy, done_count - base_done); end
        step(1);
        push_word(8'($urandom));
        push_word(8'($urandom));
        wait_done(base_done, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_done_timeout: got no done expected done"); end
        checks++; if (acc_q.size() - base_acc != 4) begin failures++; $display("FAIL stall_count: got %0d expected 4", acc_q.size() - base_acc); end
        for (int i = 0; i < 4 && base_acc + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[base_acc + i] !== model_q[i]) begin failures++; $display("FAIL stall_word%0d: got %h expected %h", i, acc_q[base_acc + i], model_q[i]); end
        end
        checks++; if (done_cyc != last_acc_cyc + 1) begin failures++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_cyc, last_acc_cyc + 1); end
        checks++; if (viol_empty != base_ve) begin failures++; $display("FAIL stall_rd_when_empty: got %0d expected 0", viol_empty - base_ve); end
        repeat (4) void'(model_q.pop_front());
        step(2);
    endtask

    task automatic test_start_ignored();
        int base_rd, base_acc, base_done;
        bit ok;
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        step(3);
        bus.m_ready = 1'b1;
        base_rd = rd_count; base_acc = acc_q.size(); base_done = done_count;
        start = 1'b1;
        len   = 8'd3;
        step(1);
        start = 1'b0;
        step(1);
        start = 1'b1;
        len   = 8'd5;
        step(1);
        start = 1'b0;
        wait_done(base_done, 40, ok);
        step(10);
        checks++; if (!ok) begin failures++; $display("FAIL restart_done_timeout: got no done expected done"); end
        checks++; if (rd_count - base_rd != 3) begin failures++; $display("FAIL restart_reads: got %0d expected 3", rd_count - base_rd); end
        checks++; if (done_count - base_done != 1) begin failures++; $display("FAIL restart_dones: got %0d expected 1", done_count - base_done); end
        checks++; if (acc_q.size() - base_acc != 3) begin failures++; $display("FAIL restart_count: got %0d expected 3", acc_q.size() - base_acc); end
        for (int i = 0; i < 3 && base_acc + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[base_acc + i] !== model_q[i]) begin failures++; $display("FAIL restart_word%0d: got %h expected %h", i, acc_q[base_acc + i], model_q[i]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_busy: got %b expected 0", busy); end
        repeat (3) void'(model_q.pop_front());
    endtask

    task automatic test_reset_mid();
        int base_rd, base_acc, base_done;
        bit ok;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        step(3);
        bus.m_ready = 1'b0;
        start = 1'b1;
        len   = 8'd4;
        step(1);
        start = 1'b0;
        step(2);
        // cycle 3: one word buffered, one in flight
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid: got %b expected 1", bus.m_valid); end
        sys_rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_rd_en: got %b expected 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %h expected 00", bus.m_data); end
`ifdef FIFO_RD_LAST_EN
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL rstmid_last: got %b expected 0", bus.m_last); end
`endif
        repeat (2) void'(model_q.pop_front());
        step(2);
        sys_rst_n = 1'b1;
        step(2);
        bus.m_ready = 1'b1;
        base_rd = rd_count; base_acc = acc_q.size(); base_done = done_count;
        start = 1'b1;
        len   = 8'd1;
        step(1);
        start = 1'b0;
        wait_done(base_done, 30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_done_timeout: got no done expected done"); end
        checks++; if (rd_count - base_rd != 1) begin failures++; $display("FAIL rstmid_reads: got %0d expected 1", rd_count - base_rd); end
        checks++;
        if (acc_q.size() - base_acc != 1 || acc_q[acc_q.size() - 1] !== model_q[0]) begin
            failures++; $display("FAIL rstmid_word: got %0d words last %h expected 1 word %h", acc_q.size() - base_acc, acc_q[acc_q.size() - 1], model_q[0]);
        end
        void'(model_q.pop_front());
        step(2);
    endtask

    task automatic test_random();
        for (int it = 0; it < 13; it++) begin
            int  blen, need, pushed, base_rd, base_acc, base_done, b_ve, b_vh, b_vb;
            bit  ok;
            blen   = (it == 12) ? 255 : int'($urandom_range(1, 20));
            need   = blen - model_q.size();
            if (need < 0) need = 0;
            pushed = 0;
            repeat ($urandom_range(0, 3)) begin
                if (pushed < need) begin push_word(8'($urandom)); pushed++; end
            end
            step(2);
            base_rd = rd_count; base_acc = acc_q.size(); base_done = done_count;
            b_ve = viol_empty; b_vh = viol_hold; b_vb = viol_buf;
            bus.m_ready = ($urandom_range(0, 3) != 0);
            start = 1'b1;
            len   = 8'(blen);
            ok = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                step(1);
                start = 1'b0;
                if (done_count > base_done) begin ok = 1'b1; break; end
                bus.m_ready = ($urandom_range(0, 3) != 0);
                if (pushed < need && $urandom_range(0, 1) == 1) begin push_word(8'($urandom)); pushed++; end
                if (busy && $urandom_range(0, 9) == 0) begin start = 1'b1; len = 8'($urandom); end
            end
            start = 1'b0;
            checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout: got no done expected done", it); end
            checks++; if (rd_count - base_rd != blen) begin failures++; $display("FAIL rnd%0d_reads: got %0d expected %0d", it, rd_count - base_rd, blen); end
            checks++; if (acc_q.size() - base_acc != blen) begin failures++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, acc_q.size() - base_acc, blen); end
            for (int i = 0; i < blen && base_acc + i < acc_q.size(); i++) begin
                checks++;
                if (acc_q[base_acc + i] !== model_q[i]) begin failures++; $display("FAIL rnd%0d_word%0d: got %h expected %h", it, i, acc_q[base_acc + i], model_q[i]); end
`ifdef FIFO_RD_LAST_EN
                checks++;
                if (acc_last_q[base_acc + i] !== (i == blen - 1)) begin failures++; $display("FAIL rnd%0d_last%0d: got %b expected %b", it, i, acc_last_q[base_acc + i], (i == blen - 1)); end
`endif
            end
            checks++; if (done_count - base_done != 1) begin failures++; $display("FAIL rnd%0d_dones: got %0d expected 1", it, done_count - base_done); end
            checks++; if (done_cyc != last_acc_cyc + 1) begin failures++; $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", it, done_cyc, last_acc_cyc + 1); end
            checks++; if (viol_empty != b_ve) begin failures++; $display("FAIL rnd%0d_rd_when_empty: got %0d expected 0", it, viol_empty - b_ve); end
            checks++; if (viol_hold != b_vh) begin failures++; $display("FAIL rnd%0d_hold: got %0d expected 0", it, viol_hold - b_vh); end
            checks++; if (viol_buf != b_vb) begin failures++; $display("FAIL rnd%0d_over_credit: got %0d expected 0", it, viol_buf - b_vb); end
            repeat (blen) void'(model_q.pop_front());
            step(2);
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_backpressure();
        test_empty_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
